s_add_arbiter: RTL

- Shares one S_ADD adder (Y = A + B, A/Y P bits, B 5 bits) between two requesters in the natural-logarithm datapath.
- Requester 0 is the exponent-adjust path; requester 1 is the iteration/shift counter.
- Provides round-robin arbitration, a REQ/ACK handshake, operand capture and a registered result.

---
 rtl/s_add_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/s_add_arbiter.sv
// s_add_arbiter: round-robin sharing of one S_ADD adder (Y = A + B) between
// the exponent-adjust path (requester 0) and the iteration/shift counter
// (requester 1) of the natural-log datapath.
//
// Optional build macro SADD_OVF_EN: adds the OVF output, which carries the
// carry out of the last completed sum. Without it the carry is not formed.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; arbitrates and latches operands
// EXEC  | adder result registered into RES, ACK raised for the winner
// DONE  | ACK dropped; REQ lines ignored so a withdrawing requester
//       | cannot be granted a second time

module s_add #(
    parameter int P = 8
) (
    input  logic [P-1:0] A,
    input  logic [4:0]   B,
`ifdef SADD_OVF_EN
    output logic         CO,
`endif
    output logic [P-1:0] Y
);

`ifdef SADD_OVF_EN
    // Widen by one bit so the carry out is kept.
    assign {CO, Y} = {1'b0, A} + {{(P - 4){1'b0}}, B};
`else
    // B is unsigned and zero-extended; the sum wraps modulo 2^P.
    assign Y = A + {{(P - 5){1'b0}}, B};
`endif

endmodule

module s_add_arbiter #(
    parameter int P  = 8,
    parameter int BW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic [P-1:0]  A0,
    input  logic [BW-1:0] B0,
    input  logic          REQ1,
    input  logic [P-1:0]  A1,
    input  logic [BW-1:0] B1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [P-1:0]  RES,
`ifdef SADD_OVF_EN
    output logic          OVF,
`endif
    output logic          GNT,
    output logic          BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic           grant;
    logic           grant_idx;
    logic           last;
    logic           gnt_q;
    logic [P-1:0]   op_a;
    logic [BW-1:0]  op_b;
    logic [P-1:0]   res_q;
    logic [P-1:0]   sum_y;
    logic           ack0_q;
    logic           ack1_q;
    logic           busy_q;
`ifdef SADD_OVF_EN
    logic           sum_co;
    logic           ovf_q;
`endif

    s_add #(
        .P (P)
    ) u_s_add (
        .A  (op_a),
        .B  (op_b),
`ifdef SADD_OVF_EN
        .CO (sum_co),
`endif
        .Y  (sum_y)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and arbitration; on a tie the requester not served last wins.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_idx  = 1'b0;
        case (state)
            IDLE: begin
                if (REQ0 && REQ1) begin
                    grant     = 1'b1;
                    grant_idx = ~last;
                end else if (REQ0) begin
                    grant     = 1'b1;
                    grant_idx = 1'b0;
                end else if (REQ1) begin
                    grant     = 1'b1;
                    grant_idx = 1'b1;
                end
                if (grant) begin
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on grant, result/ACK in EXEC, ACK release in DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last   <= 1'b1;
            gnt_q  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            res_q  <= '0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef SADD_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            busy_q <= (state_next != IDLE);
            if (grant) begin
                op_a  <= grant_idx ? A1 : A0;
                op_b  <= grant_idx ? B1 : B0;
                gnt_q <= grant_idx;
                last  <= grant_idx;
            end
            if (state == EXEC) begin
                res_q  <= sum_y;
                ack0_q <= ~gnt_q;
                ack1_q <= gnt_q;
`ifdef SADD_OVF_EN
                ovf_q  <= sum_co;
`endif
            end else if (state == DONE) begin
                ack0_q <= 1'b0;
                ack1_q <= 1'b0;
            end
        end
    end

    assign ACK0 = ack0_q;
    assign ACK1 = ack1_q;
    assign RES  = res_q;
    assign GNT  = gnt_q;
    assign BUSY = busy_q;
`ifdef SADD_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule
